imm_extend_pipe: RTL

Pipelined, parametrised immediate extender for the decode stage. It accepts an instruction immediate field and an ImmSrc mode through a valid/ready handshake. It produces a DATA_W-wide extended immediate one cycle later, and a two-entry skid buffer gives full throughput under backpressure. Beyond the plain 8-bit/12-bit/branch extension of the previous generation, it adds ARM-style rotated 8-bit immediates, a signed 12-bit mode, a configurable branch shift and a pass-through tag.

---
 rtl/imm_extend_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate extender: one registered output stage plus a skid
// register, so the block runs at full rate and in_ready never depends on out_ready.
module imm_extend_pipe #(
  parameter int DATA_W   = 32,
  parameter int INSTR_W  = 24,
  parameter int BR_SHIFT = 2,
  parameter bit ROT_EN   = 1'b1,
  parameter int TAG_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [1:0]         in_immsrc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q,  o_data_d;
  logic [TAG_W-1:0]  o_tag_q,   o_tag_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [TAG_W-1:0]  s_tag_q,   s_tag_d;

  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] ext_data;

  function automatic logic [DATA_W-1:0] extend(input logic [INSTR_W-1:0] instr,
                                                input logic [1:0]         mode);
    logic [DATA_W-1:0]        z8;
    logic [2*DATA_W-1:0]      dbl;
    logic signed [DATA_W-1:0] br;
    logic [DATA_W-1:0]        res;
    int                       rot;
    z8  = DATA_W'(instr[7:0]);
    dbl = '0;
    br  = '0;
    rot = 0;
    res = '0;
    unique case (mode)
      2'b00: begin
        if (ROT_EN) begin
          // Rotate right by shifting a doubled copy; the low half is the result.
          rot = (2 * int'(instr[11:8])) % DATA_W;
          dbl = {z8, z8} >> rot;
          res = dbl[DATA_W-1:0];
        end else begin
          res = z8;
        end
      end
      2'b01: res = DATA_W'(instr[11:0]);
      2'b10: begin
        br  = DATA_W'($signed(instr));
        res = br <<< BR_SHIFT;
      end
      default: res = DATA_W'($signed(instr[11:0]));
    endcase
    return res;
  endfunction

  assign ext_data  = extend(in_instr, in_immsrc);
  assign in_ready  = !s_valid_q;
  assign accept    = in_valid && !s_valid_q;
  assign drain     = o_valid_q && out_ready;
  assign out_valid = o_valid_q;
  assign out_data  = o_data_q;
  assign out_tag   = o_tag_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_tag_d   = o_tag_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_tag_d   = s_tag_q;
    if (s_valid_q) begin
      if (drain) begin
        o_data_d  = s_data_q;
        o_tag_d   = s_tag_q;
        s_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!o_valid_q || drain) begin
        o_valid_d = 1'b1;
        o_data_d  = ext_data;
        o_tag_d   = in_tag;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = ext_data;
        s_tag_d   = in_tag;
      end
    end else if (drain) begin
      o_valid_d = 1'b0;
    end
  end

  // NOTE: payload registers are reset too, since out_data/out_tag must read
  // zero while rst_n is low; S is cleared alongside for a clean restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_tag_q   <= o_tag_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_tag_q   <= s_tag_d;
    end
  end

endmodule
